rtdf_flow_controller: RTL and testbench

Flow and recovery controller for the real-time data feed, clocked in the sample domain. It sequences start-up (link up, then FIFO prefill, then run), applies hysteresis backpressure on the packet processor input, and detects starvation and stalled reads. On a fault it issues a timed reset pulse to the packet processor and RX FIFO. It drives the sample generator's `halt`, the processor's `halt_packet` and the processor reset, and reports fault counters for debug.

---
 rtl/rtdf_flow_controller.sv | 119 +++++++++++
 tb/tb_rtdf_flow_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rtdf_flow_controller.sv
// Sample-domain flow/recovery controller: start-up sequencing, hysteresis backpressure, starvation and stall recovery.
// One-cycle latency with all outputs registered from next state; halt_packet stalls RX FIFO reads into the processor.
module rtdf_flow_controller #(
    parameter logic [8:0]  START_LEVEL  = 9'd128,
    parameter logic [8:0]  HIGH_WATER   = 9'd480,
    parameter logic [8:0]  LOW_WATER    = 9'd384,
    parameter logic [15:0] STARVE_LIMIT = 16'd1000,
    parameter logic [15:0] WDOG_LIMIT   = 16'd50000,
    parameter logic [7:0]  RESET_CYCLES = 8'd16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       link_status,
    input  logic       packet_empty,
    input  logic       packet_read,
    input  logic [8:0] words_available,
    output logic       halt,
    output logic       halt_packet,
    output logic       proc_reset,
    output logic       running,
    output logic [2:0] state,
    output logic [8:0] underrun_count,
    output logic [8:0] recovery_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREFILL = 3'd1,
        RUN     = 3'd2,
        STARVED = 3'd3,
        RECOVER = 3'd4
    } fc_state_t;

    fc_state_t   state_q;
    fc_state_t   state_nxt;
    logic [15:0] timer;
    logic [15:0] timer_nxt;
    logic        halt_packet_nxt;
    logic        armed;

    assign state = state_q;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (link_status && enable) state_nxt = PREFILL;
            end
            PREFILL: begin
                if (words_available >= START_LEVEL)        state_nxt = RUN;
                else if (timer == WDOG_LIMIT - 16'd1)      state_nxt = RECOVER;
            end
            RUN: begin
                if (packet_empty)                          state_nxt = STARVED;
                else if (timer == WDOG_LIMIT - 16'd1)      state_nxt = RECOVER;
            end
            STARVED: begin
                if (words_available >= START_LEVEL)        state_nxt = RUN;
                else if (timer == STARVE_LIMIT - 16'd1)    state_nxt = RECOVER;
            end
            RECOVER: begin
                if (timer == {8'd0, RESET_CYCLES} - 16'd1) state_nxt = PREFILL;
            end
            default: state_nxt = IDLE;
        endcase
        // Losing link or enable wins over everything, truncating any reset pulse.
        if (!link_status || !enable) state_nxt = IDLE;
    end

    always_comb begin
        timer_nxt = timer;
        if (state_nxt != state_q)
            timer_nxt = 16'd0;
        else if (state_q == RUN && (packet_read || packet_empty))
            timer_nxt = 16'd0;
        else if (timer != 16'hFFFF)
            timer_nxt = timer + 16'd1;
    end

    always_comb begin
        halt_packet_nxt = halt_packet;
        if (state_nxt == IDLE || state_nxt == RECOVER)
            halt_packet_nxt = 1'b0;
        else if (words_available >= HIGH_WATER)
            halt_packet_nxt = 1'b1;
        else if (words_available < LOW_WATER)
            halt_packet_nxt = 1'b0;
    end

    // armed delays the first state change to the second edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed          <= 1'b0;
            state_q        <= IDLE;
            timer          <= 16'd0;
            halt           <= 1'b1;
            halt_packet    <= 1'b0;
            proc_reset     <= 1'b0;
            running        <= 1'b0;
            underrun_count <= 9'd0;
            recovery_count <= 9'd0;
        end else if (!armed) begin
            armed <= 1'b1;
        end else begin
            state_q     <= state_nxt;
            timer       <= timer_nxt;
            halt        <= (state_nxt != RUN);
            running     <= (state_nxt == RUN);
            proc_reset  <= (state_nxt == RECOVER);
            halt_packet <= halt_packet_nxt;
            if (state_q == RUN && state_nxt == STARVED && underrun_count != 9'h1FF)
                underrun_count <= underrun_count + 9'd1;
            if (state_q != RECOVER && state_nxt == RECOVER && recovery_count != 9'h1FF)
                recovery_count <= recovery_count + 9'd1;
        end
    end

endmodule

// File: tb/tb_rtdf_flow_controller.sv
// Bench for rtdf_flow_controller: vector table plus hand-written start-up, watchdog, recovery and saturation sequences.
module tb_rtdf_flow_controller;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PREFILL = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_STARVED = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       link_status;
    logic       packet_empty;
    logic       packet_read;
    logic [8:0] words_available;
    logic       halt;
    logic       halt_packet;
    logic       proc_reset;
    logic       running;
    logic [2:0] state;
    logic [8:0] underrun_count;
    logic [8:0] recovery_count;

    rtdf_flow_controller dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .link_status     (link_status),
        .packet_empty    (packet_empty),
        .packet_read     (packet_read),
        .words_available (words_available),
        .halt            (halt),
        .halt_packet     (halt_packet),
        .proc_reset      (proc_reset),
        .running         (running),
        .state           (state),
        .underrun_count  (underrun_count),
        .recovery_count  (recovery_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic       hp;
        int         u;
        int         r;
    } exp_t;

    typedef struct {
        logic       en;
        logic       link;
        logic       empty;
        logic       rd;
        logic [8:0] words;
        exp_t       e;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[27];
    int   checks = 0;
    int   passes = 0;
    int   u_exp  = 0;
    int   r_exp  = 0;

    function automatic vec_t mk(input logic en, input logic link, input logic empty, input logic rd,
                                input logic [8:0] words, input logic [2:0] st, input logic hp,
                                input int u, input int r);
        vec_t v;
        v.en = en; v.link = link; v.empty = empty; v.rd = rd; v.words = words;
        v.e.st = st; v.e.hp = hp; v.e.u = u; v.e.r = r;
        return v;
    endfunction

    task automatic compare(input exp_t e, input string nm);
        logic exp_halt, exp_run, exp_pr;
        exp_halt = (e.st != S_RUN);
        exp_run  = (e.st == S_RUN);
        exp_pr   = (e.st == S_RECOVER);
        checks++;
        if (state === e.st && halt === exp_halt && running === exp_run && proc_reset === exp_pr &&
            halt_packet === e.hp && int'(underrun_count) == e.u && int'(recovery_count) == e.r) begin
            passes++;
        end else begin
            $display("FAIL %s: got state=%0d halt=%b run=%b prst=%b hp=%b ucnt=%0d rcnt=%0d; want state=%0d halt=%b run=%b prst=%b hp=%b ucnt=%0d rcnt=%0d",
                     nm, state, halt, running, proc_reset, halt_packet, underrun_count, recovery_count,
                     e.st, exp_halt, exp_run, exp_pr, e.hp, e.u, e.r);
        end
    endtask

    task automatic drive(input logic en, input logic link, input logic empty, input logic rd,
                         input logic [8:0] words);
        enable          = en;
        link_status     = link;
        packet_empty    = empty;
        packet_read     = rd;
        words_available = words;
    endtask

    task automatic tick(input logic en, input logic link, input logic empty, input logic rd,
                        input logic [8:0] words);
        drive(en, link, empty, rd, words);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic en, input logic link, input logic empty, input logic rd,
                        input logic [8:0] words, input logic [2:0] st, input logic hp,
                        input int u, input int r, input string nm);
        exp_t e;
        e.st = st; e.hp = hp; e.u = u; e.r = r;
        drive(en, link, empty, rd, words);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare(exp_q.pop_front(), nm);
    endtask

    initial begin
        exp_t rst_e;
        rst_e.st = S_IDLE; rst_e.hp = 1'b0; rst_e.u = 0; rst_e.r = 0;

        // Start-up ramp, hysteresis sweep, short starvation and read/empty collision.
        tbl[0] = mk(1, 1, 0, 0, 9'd0,   S_IDLE,    0, 0, 0);
        tbl[1] = mk(1, 1, 0, 0, 9'd0,   S_PREFILL, 0, 0, 0);
        tbl[2] = mk(1, 1, 0, 0, 9'd64,  S_PREFILL, 0, 0, 0);
        tbl[3] = mk(1, 1, 0, 0, 9'd127, S_PREFILL, 0, 0, 0);
        tbl[4] = mk(1, 1, 0, 0, 9'd128, S_RUN,     0, 0, 0);
        tbl[5] = mk(1, 1, 0, 1, 9'd470, S_RUN,     0, 0, 0);
        tbl[6] = mk(1, 1, 0, 1, 9'd479, S_RUN,     0, 0, 0);
        tbl[7] = mk(1, 1, 0, 1, 9'd480, S_RUN,     1, 0, 0);
        tbl[8] = mk(1, 1, 0, 1, 9'd490, S_RUN,     1, 0, 0);
        tbl[9] = mk(1, 1, 0, 1, 9'd400, S_RUN,     1, 0, 0);
        tbl[10] = mk(1, 1, 0, 1, 9'd384, S_RUN,    1, 0, 0);
        tbl[11] = mk(1, 1, 0, 1, 9'd383, S_RUN,    0, 0, 0);
        tbl[12] = mk(1, 1, 0, 1, 9'd480, S_RUN,    1, 0, 0);
        tbl[13] = mk(1, 1, 0, 1, 9'd380, S_RUN,    0, 0, 0);
        for (int i = 14; i < 24; i++)
            tbl[i] = mk(1, 1, 1, 0, 9'd100, S_STARVED, 0, 1, 0);
        tbl[24] = mk(1, 1, 0, 0, 9'd128, S_RUN,     0, 1, 0);
        tbl[25] = mk(1, 1, 1, 1, 9'd200, S_STARVED, 0, 2, 0);
        tbl[26] = mk(1, 1, 0, 0, 9'd128, S_RUN,     0, 2, 0);

        reset_n = 1'b0;
        drive(1, 1, 0, 0, 9'd0);
        repeat (3) @(posedge clk);
        #1;
        compare(rst_e, "reset_state");
        reset_n = 1'b1;

        for (int i = 0; i < 27; i++)
            step(tbl[i].en, tbl[i].link, tbl[i].empty, tbl[i].rd, tbl[i].words,
                 tbl[i].e.st, tbl[i].e.hp, tbl[i].e.u, tbl[i].e.r, $sformatf("vec%0d", i));
        u_exp = 2;

        // Read-stall watchdog: exactly WDOG_LIMIT idle cycles in RUN.
        step(1, 1, 0, 1, 9'd200, S_RUN, 0, u_exp, r_exp, "wdog_clear");
        for (int i = 0; i < 49998; i++) tick(1, 1, 0, 0, 9'd200);
        step(1, 1, 0, 0, 9'd200, S_RUN, 0, u_exp, r_exp, "wdog_last_run");
        r_exp = 1;
        step(1, 1, 0, 0, 9'd200, S_RECOVER, 0, u_exp, r_exp, "wdog_recover");
        for (int i = 1; i < 16; i++)
            step(1, 1, 0, 0, 9'd200, S_RECOVER, 0, u_exp, r_exp, $sformatf("pulse%0d", i));
        step(1, 1, 0, 0, 9'd200, S_PREFILL, 0, u_exp, r_exp, "pulse_end");
        step(1, 1, 0, 0, 9'd200, S_RUN, 0, u_exp, r_exp, "refill_run");

        // Starvation timeout, then link drop in the 5th RECOVER cycle.
        u_exp = 3;
        step(1, 1, 1, 0, 9'd100, S_STARVED, 0, u_exp, r_exp, "starve_enter");
        for (int i = 0; i < 998; i++) tick(1, 1, 1, 0, 9'd100);
        step(1, 1, 1, 0, 9'd100, S_STARVED, 0, u_exp, r_exp, "starve_last");
        r_exp = 2;
        step(1, 1, 1, 0, 9'd100, S_RECOVER, 0, u_exp, r_exp, "starve_recover");
        for (int i = 1; i < 5; i++)
            step(1, 1, 0, 0, 9'd490, S_RECOVER, 0, u_exp, r_exp, $sformatf("rec_cyc%0d", i));
        step(1, 0, 0, 0, 9'd490, S_IDLE,    0, u_exp, r_exp, "link_drop");
        step(1, 1, 0, 0, 9'd490, S_PREFILL, 1, u_exp, r_exp, "relink_prefill");
        step(1, 1, 0, 1, 9'd490, S_RUN,     1, u_exp, r_exp, "relink_run");
        step(1, 1, 0, 1, 9'd200, S_RUN,     0, u_exp, r_exp, "relink_hp_low");

        // 600 starvations: underrun counter must stick at 511.
        for (int i = 0; i < 600; i++) begin
            if (u_exp < 511) u_exp++;
            step(1, 1, 1, 0, 9'd128, S_STARVED, 0, u_exp, r_exp, "sat_starve");
            step(1, 1, 1, 0, 9'd128, S_RUN,     0, u_exp, r_exp, "sat_run");
        end

        // Asynchronous reset mid-RUN, no clock edge allowed in between.
        drive(1, 1, 0, 1, 9'd490);
        reset_n = 1'b0;
        #2;
        compare(rst_e, "async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        u_exp = 0;
        r_exp = 0;
        step(1, 1, 0, 0, 9'd0, S_IDLE,    0, u_exp, r_exp, "rel_hold");
        step(1, 1, 0, 0, 9'd0, S_PREFILL, 0, u_exp, r_exp, "rel_prefill");
        step(0, 1, 0, 0, 9'd0, S_IDLE,    0, u_exp, r_exp, "enable_drop");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
